// File: rtl/div_pkg.sv
// Shared definitions for the iterative integer divider.
// Holds the operand width, the op encodings and the FSM state encoding.
package div_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/div_counter.sv
// Loadable down-counter that sequences the divider iterations.
// load has priority over decrement; both need en.
module div_counter #(
    parameter int W = 5,
    parameter int V = 31
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         load,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (en) begin
            count <= load ? W'(V) : count - W'(1);
        end
    end

endmodule

// File: rtl/alu_div_unit.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle; zero-divisor and overflow finish at once.
module alu_div_unit #(
    parameter int XLEN = div_pkg::XLEN,
    parameter int CW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);
    import div_pkg::*;

    state_e          state, state_nx;
    logic [1:0]      op_q;
    logic            qsign, rsign;
    logic [XLEN-1:0] quo, dvsr, rem;
    logic [CW-1:0]   count;

    logic            accept, busy, last;
    logic            is_signed, a_neg, b_neg;
    logic            div_zero, overflow, special;
    logic [XLEN-1:0] a_mag, b_mag, special_res;
    logic [XLEN:0]   shifted, trial;
    logic            fits;
    logic [XLEN-1:0] quo_nx, rem_nx, final_res;
    logic            neg_q, neg_r, is_rem_q;

    assign busy  = (state == S_BUSY);
    assign ready = !busy;
    assign done  = (state == S_DONE);
    assign last  = (count == '0);

    assign is_signed = op inside {OP_DIV, OP_REM};
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign a_mag     = a_neg ? -dividend : dividend;
    assign b_mag     = b_neg ? -divisor : divisor;

    assign div_zero = (divisor == '0);
    assign overflow = is_signed
                    & (dividend == {1'b1, {(XLEN-1){1'b0}}})
                    & (divisor == '1);
    assign special  = div_zero | overflow;

    // Overflow quotient equals the dividend itself (most-negative value)
    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = op[1] ? dividend : '1;
        end else if (!op[1]) begin
            special_res = dividend;
        end
    end

    // 33-bit partial remainder: shifted-in bit plus the running remainder
    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, dvsr};
    assign fits    = !trial[XLEN];
    assign rem_nx  = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_nx  = {quo[XLEN-2:0], fits};

    assign is_rem_q  = op_q inside {OP_REM, OP_REMU};
    assign neg_q     = qsign & (op_q inside {OP_DIV, OP_REM});
    assign neg_r     = rsign & (op_q inside {OP_DIV, OP_REM});
    assign final_res = is_rem_q ? (neg_r ? -rem_nx : rem_nx)
                                : (neg_q ? -quo_nx : quo_nx);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = special ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (flush) begin
            state_nx = S_IDLE;
            accept   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            qsign  <= 1'b0;
            rsign  <= 1'b0;
            quo    <= '0;
            dvsr   <= '0;
            rem    <= '0;
            result <= '0;
        end else if (accept) begin
            op_q  <= op;
            qsign <= a_neg ^ b_neg;
            rsign <= a_neg;
            quo   <= a_mag;
            dvsr  <= b_mag;
            rem   <= '0;
            if (special) begin
                result <= special_res;
            end
        end else if (busy && !flush) begin
            quo <= quo_nx;
            rem <= rem_nx;
            if (last) begin
                result <= final_res;
            end
        end
    end

    div_counter #(
        .W (CW),
        .V (XLEN-1)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .en    (accept | busy),
        .load  (accept),
        .count (count)
    );

endmodule

// File: tb/tb_alu_div_unit.sv
// Directed bench for alu_div_unit: literal vectors plus a cycle-level
// reference model checked on every falling edge.
module tb_alu_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        ready;
    logic        done;
    logic [31:0] result;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_div_unit #(.XLEN(32), .CW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .flush    (flush),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural RISC-V division semantics
    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return o[1] ? 32'h0 : 32'h8000_0000;
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] o,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Model: edges left until done, pending result, expected outputs
    int          m_left;
    logic        m_done;
    logic [31:0] m_res;
    logic [31:0] m_pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_pend <= '0;
        end else begin
            m_done <= 1'b0;
            if (flush) begin
                m_left <= 0;
            end else if (start && m_left == 0) begin
                if (is_special(op, dividend, divisor)) begin
                    m_done <= 1'b1;
                    m_res  <= ref_div(op, dividend, divisor);
                end else begin
                    m_left <= 32;
                    m_pend <= ref_div(op, dividend, divisor);
                end
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    m_res  <= m_pend;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_ready", {31'b0, ready}, {31'b0, m_left == 0});
        check("cyc_done", {31'b0, done}, {31'b0, m_done});
        if (m_done) check("cyc_result", result, m_res);
    end

    typedef struct {
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic do_op(input string name, input vec_t v, input bit b2b);
        int n;
        if (!b2b) begin
            @(posedge clk);
            #2;
        end
        start    = 1'b1;
        op       = v.o;
        dividend = v.a;
        divisor  = v.b;
        @(posedge clk);
        #2;
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0003;
        n = 1;
        while (!done && n < 40) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({name, "_lat"}, n, v.lat);
        check({name, "_res"}, result, v.exp);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #2;
            if (done) pulses++;
        end
        check({name, "_pulses"}, pulses, 0);
        check({name, "_ready"}, {31'b0, ready}, 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        flush    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;

        vecs.push_back('{2'b01, 32'd100, 32'd7, 32'd14, 33});
        vecs.push_back('{2'b11, 32'd100, 32'd7, 32'd2, 33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1});
        vecs.push_back('{2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{2'b10, 32'd5, 32'd0, 32'd5, 1});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1});
        vecs.push_back('{2'b00, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33});
        vecs.push_back('{2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33});
        vecs.push_back('{2'b00, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 32'd4, 33});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 33});
        vecs.push_back('{2'b11, 32'h8000_0000, 32'd3, 32'd2, 33});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33});
        vecs.push_back('{2'b11, 32'd0, 32'd5, 32'd0, 33});

        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) do_op($sformatf("vec%0d", i), vecs[i], 1'b0);

        // Back-to-back: each new start lands in the previous DONE cycle
        do_op("b2b_a", '{2'b01, 32'd1000, 32'd9, 32'd111, 33}, 1'b0);
        do_op("b2b_b", '{2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33}, 1'b1);
        do_op("b2b_c", '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1}, 1'b1);
        do_op("b2b_d", '{2'b11, 32'd100, 32'd7, 32'd2, 33}, 1'b1);

        // Start pulses during BUSY with other operands must be ignored
        fork
            do_op("ignore", '{2'b01, 32'd1000, 32'd10, 32'd100, 33}, 1'b0);
            begin
                repeat (6) @(posedge clk);
                #3;
                start    = 1'b1;
                op       = 2'b00;
                dividend = 32'd9;
                divisor  = 32'd0;
                @(posedge clk);
                #3;
                start = 1'b0;
                repeat (8) @(posedge clk);
                #3;
                start    = 1'b1;
                op       = 2'b11;
                dividend = 32'd77;
                divisor  = 32'd5;
                @(posedge clk);
                #3;
                start = 1'b0;
            end
        join

        // Flush after 10 iterations
        @(posedge clk);
        #2;
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        watch_no_done("flush", 40);
        do_op("post_flush", '{2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33}, 1'b0);

        // Reset after 20 iterations
        @(posedge clk);
        #2;
        start    = 1'b1;
        op       = 2'b01;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'b0, ready}, 32'd1);
        check("mid_rst_done", {31'b0, done}, 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        watch_no_done("reset", 40);
        do_op("post_reset", '{2'b11, 32'd100, 32'd7, 32'd2, 33}, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
